reg_stream_sink: RTL
====================

Name: reg_stream_sink

Overview:
Receiving end of the registered data/valid stream produced by the team's registered-output test modules (registered data bus plus a one-bit valid, no backpressure). Captures every valid beat into a small first-word-fall-through FIFO. Re-presents the beats downstream on a valid/ready handshake. Flags and counts beats lost because the producer cannot be stalled. Port names deliberately carry 'reg'/'wire' tokens so the block also exercises the wrapper generator's port parsing.

Parameters:
WIDTH, 8, data width of both stream sides
DEPTH, 4, FIFO entries; power of two, >= 2
AW, $clog2(DEPTH), localparam, pointer width (not overridable)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
reg_data  input  WIDTH  incoming beat data, sampled when reg_valid=1
reg_valid  input  1  incoming beat qualifier; producer ignores backpressure
wire_data  output  WIDTH  head-of-FIFO data; 0 whenever wire_valid=0
wire_valid  output  1  FIFO not empty
wire_ready  input  1  downstream accepts head when wire_valid&wire_ready
reg_level  output  AW+1  current occupancy, 0..DEPTH
reg_overflow  output  1  sticky: at least one beat dropped
clear_overflow  input  1  synchronous clear of reg_overflow (and drop_count)
drop_count  output  16  dropped-beat counter (only with REG_SINK_DROP_CNT_EN)

Behaviour:
- Reset (reset=0, async): rd/wr pointers=0, reg_level=0, wire_valid=0, wire_data=0, reg_overflow=0, drop_count=0. Memory contents are not reset.
- Pop: wire_valid & wire_ready at an edge; rd_ptr increments mod DEPTH.
- Push: reg_valid & (reg_level<DEPTH | pop) at an edge; mem[wr_ptr]<=reg_data, wr_ptr increments mod DEPTH.
- Full with simultaneous push and pop: both occur, level stays DEPTH, no drop.
- Empty: a push-and-pop in the same cycle cannot occur because wire_valid=0. The beat is stored and a pop is possible next cycle (no combinational bypass).
- Latency: a beat accepted at edge N is visible on wire_data/wire_valid after edge N (1 cycle), when the FIFO was empty. Order is strictly FIFO.
- wire_data = mem[rd_ptr] when wire_valid, else 0. The output is stable while wire_valid & !wire_ready.
- reg_level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Drop: reg_valid & reg_level==DEPTH & !pop. The beat is discarded and the FIFO is unchanged. reg_overflow sets at that edge.
- clear_overflow=1: reg_overflow<=0, except that a drop in the same cycle wins and reg_overflow stays 1.
- Pointers wrap from DEPTH-1 to 0 with no bubble.
- Reset mid-stream: all in-flight beats are lost and outputs return to reset values immediately. The first reg_valid after release is captured normally.

Optional Feature:
Macro REG_SINK_DROP_CNT_EN.
- Defined: the drop_count port exists.
  - +1 on each drop edge, saturating at 16'hFFFF.
  - clear_overflow=1 loads 0, or loads 1 if a drop occurs in that same cycle.
  - Reset value 0.
- Undefined: the drop_count port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset release, wire_ready=1, reg_valid pulses with reg_data=8'hA5 -> wire_valid=1, wire_data=8'hA5 exactly one cycle later. reg_level returns to 0 after the pop.
- wire_ready=0, push 8'h01..8'h04 on consecutive cycles -> reg_level=4, wire_data=8'h01, reg_overflow=0. Then raise wire_ready -> 01,02,03,04 out in order, one per cycle.
- FIFO full, wire_ready=0, reg_valid=1 with 8'h55 -> beat dropped, reg_overflow=1, reg_level stays 4. With REG_SINK_DROP_CNT_EN, drop_count=1.
- FIFO full, wire_ready=1, reg_valid=1 for 10 cycles with incrementing data -> no drops, reg_level stays 4, output sequence contiguous across pointer wrap.
- reg_overflow=1, clear_overflow=1 in the same cycle as another drop -> reg_overflow stays 1 and drop_count=1. Next clear with no drop -> reg_overflow=0, drop_count=0.
- reset=0 asserted mid-burst with reg_level=3 -> wire_valid=0, wire_data=0, reg_level=0 without waiting for a clock edge. After release, a push of 8'hC3 appears one cycle later.

Source files
------------

// File: rtl/reg_stream_sink.sv
// ============================================================================
//  Module      : reg_stream_sink
//  Description : Captures a registered data/valid stream (no backpressure)
//                into a first-word-fall-through FIFO and re-presents it on a
//                valid/ready handshake, flagging and optionally counting drops.
//                Optional macro REG_SINK_DROP_CNT_EN adds the drop_count port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_stream_sink #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             reg_valid,
    output logic [WIDTH-1:0] wire_data,
    output logic             wire_valid,
    input  logic             wire_ready,
    output logic [AW:0]      reg_level,
    output logic             reg_overflow,
`ifdef REG_SINK_DROP_CNT_EN
    output logic [15:0]      drop_count,
`endif
    input  logic             clear_overflow
);

    localparam logic [AW:0] C_FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full = (r_level == C_FULL_LEVEL);
    assign w_pop  = wire_valid & wire_ready;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign w_push = reg_valid & (~w_full | w_pop);
    assign w_drop = reg_valid & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= reg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            // A drop in the clearing cycle keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef REG_SINK_DROP_CNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_count <= '0;
        end else if (clear_overflow) begin
            r_drop_count <= {15'd0, w_drop};
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign wire_valid   = (r_level != '0);
    assign wire_data    = wire_valid ? r_mem[r_rd_ptr] : '0;
    assign reg_level    = r_level;
    assign reg_overflow = r_overflow;

endmodule

`default_nettype wire
